// File: rtl/uart_rx_nbytes.sv
// uart_rx_nbytes: 8N1 UART receiver, oversampled, LSB first.
// Packs Nbytes consecutive frames into one word; pulses on completion.
module uart_rx_nbytes #(
    parameter int Nbytes     = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_en,
    input  logic                  rx_lane,
    output logic [Nbytes*8-1:0]   rx_data,
    output logic                  rx_valid,
    output logic                  rx_frame_err,
    output logic                  rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (Nbytes > 1) ? $clog2(Nbytes) : 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(Nbytes - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [1:0]           sync;
    logic                 line;
    logic [TW-1:0]        tick;
    logic [2:0]           bit_idx;
    logic [BW-1:0]        byte_idx;
    logic [7:0]           shreg;
    logic [Nbytes*8-1:0]  word_buf;
    logic [Nbytes*8-1:0]  word_n;
    logic                 tick_half;
    logic                 tick_last;
    logic                 data_smp;
    logic                 stop_ok;
    logic                 stop_bad;

    assign line      = sync[1];
    assign tick_half = (tick == TICK_HALF);
    assign tick_last = (tick == TICK_LAST);

    // Two-flop synchronizer; idles high so reset looks like a quiet line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], rx_lane};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state logic; nothing moves without a tick.
    always_comb begin
        state_n = state;
        if (rx_en) begin
            unique case (state)
                S_IDLE:  if (!line) state_n = S_START;
                S_START: if (tick_half) state_n = line ? S_IDLE : S_DATA;
                S_DATA:  if (tick_last && bit_idx == 3'd7) state_n = S_STOP;
                S_STOP:  if (tick_last) state_n = line ? S_IDLE : S_BREAK;
                S_BREAK: if (line) state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Output and sample-event decode, plus the word with the new byte merged.
    always_comb begin
        rx_busy  = (state != S_IDLE);
        data_smp = rx_en && (state == S_DATA) && tick_last;
        stop_ok  = rx_en && (state == S_STOP) && tick_last && line;
        stop_bad = rx_en && (state == S_STOP) && tick_last && !line;
        word_n   = word_buf;
        for (int k = 0; k < Nbytes; k++) begin
            if (byte_idx == BW'(k)) word_n[k*8 +: 8] = shreg;
        end
    end

    // Tick and bit counters; tick restarts on every transition and bit centre.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick    <= '0;
            bit_idx <= '0;
        end else if (rx_en) begin
            if (state_n != state || tick_last)
                tick <= '0;
            else if (state == S_IDLE || state == S_BREAK)
                tick <= '0;
            else
                tick <= tick + 1'b1;
            if (state == S_START && state_n == S_DATA)
                bit_idx <= '0;
            else if (data_smp)
                bit_idx <= bit_idx + 3'd1;
        end
    end

    // Shift in data, collect bytes, publish full words and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg        <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            if (data_smp) shreg <= {line, shreg[7:1]};
            if (stop_ok) begin
                word_buf <= word_n;
                if (byte_idx == BYTE_LAST) begin
                    rx_data  <= word_n;
                    rx_valid <= 1'b1;
                    byte_idx <= '0;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
            if (stop_bad) begin
                rx_frame_err <= 1'b1;
                byte_idx     <= '0;
                word_buf     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_nbytes.sv
// tb_uart_rx_nbytes: scoreboard bench for uart_rx_nbytes.
// One instance per word width; both lanes are driven in parallel.
module tb_uart_rx_nbytes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rx_en = 1'b0;
    int unsigned en_cnt = 0;
    always @(posedge clk) begin
        if (en_cnt == 53) begin
            en_cnt <= 0;
            rx_en  <= 1'b1;
        end else begin
            en_cnt <= en_cnt + 1;
            rx_en  <= 1'b0;
        end
    end

    logic rst1_n = 1'b0;
    logic rst2_n = 1'b0;
    logic lane1  = 1'b1;
    logic lane2  = 1'b1;
    logic [7:0]  d1;
    logic [15:0] d2;
    logic v1, e1, b1, v2, e2, b2;

    uart_rx_nbytes #(.Nbytes(1), .OVERSAMPLE(16)) dut1 (
        .clk(clk), .rst_n(rst1_n), .rx_en(rx_en), .rx_lane(lane1),
        .rx_data(d1), .rx_valid(v1), .rx_frame_err(e1), .rx_busy(b1)
    );

    uart_rx_nbytes #(.Nbytes(2), .OVERSAMPLE(16)) dut2 (
        .clk(clk), .rst_n(rst2_n), .rx_en(rx_en), .rx_lane(lane2),
        .rx_data(d2), .rx_valid(v2), .rx_frame_err(e2), .rx_busy(b2)
    );

    typedef struct {
        bit          err;
        logic [15:0] data;
    } ev_t;

    ev_t q1[$];
    ev_t q2[$];
    ev_t ev1, ev2;
    int nchk = 0;
    int nerr = 0;

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitors: every output pulse must match the next expected event.
    always @(negedge clk) begin
        if (v1 || e1) begin
            if (q1.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL dut1_unexpected: valid=%b err=%b data=%h want none",
                         v1, e1, d1);
            end else begin
                ev1 = q1.pop_front();
                check("dut1_kind", {14'b0, v1, e1}, {14'b0, !ev1.err, ev1.err});
                check("dut1_data", {8'h00, d1}, ev1.data);
            end
        end
    end

    always @(negedge clk) begin
        if (v2 || e2) begin
            if (q2.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL dut2_unexpected: valid=%b err=%b data=%h want none",
                         v2, e2, d2);
            end else begin
                ev2 = q2.pop_front();
                check("dut2_kind", {14'b0, v2, e2}, {14'b0, !ev2.err, ev2.err});
                check("dut2_data", d2, ev2.data);
            end
        end
    end

    task automatic wait_ticks(int n);
        repeat (n) begin
            do @(negedge clk); while (!rx_en);
            @(negedge clk);
        end
    endtask

    task automatic set_lane(int which, logic v);
        if (which == 1) lane1 = v;
        else            lane2 = v;
    endtask

    function automatic logic get_busy(int which);
        return (which == 1) ? b1 : b2;
    endfunction

    task automatic send(int which, logic [7:0] b, bit stop,
                        output bit busy_pre, output bit busy_post);
        set_lane(which, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            set_lane(which, b[i]);
            wait_ticks(16);
        end
        set_lane(which, stop);
        wait_ticks(8);
        busy_pre = get_busy(which);
        wait_ticks(1);
        busy_post = get_busy(which);
        wait_ticks(7);
        if (!stop) wait_ticks(20);
        set_lane(which, 1'b1);
    endtask

    task automatic run_dut1();
        bit bp, bq;
        logic [7:0] pat;
        q1.push_back('{1'b0, 16'h0055});
        send(1, 8'h55, 1'b1, bp, bq);
        check("t1_busy_before_stop_centre", 16'(bp), 16'h1);
        check("t1_busy_after_stop_centre", 16'(bq), 16'h0);
        wait_ticks(4);

        set_lane(1, 1'b0);
        wait_ticks(3);
        check("glitch_busy_high", 16'(b1), 16'h1);
        set_lane(1, 1'b1);
        wait_ticks(8);
        check("glitch_busy_low", 16'(b1), 16'h0);
        wait_ticks(4);
        q1.push_back('{1'b0, 16'h0000});
        send(1, 8'h00, 1'b1, bp, bq);
        wait_ticks(4);

        q1.push_back('{1'b1, 16'h0000});
        send(1, 8'h0F, 1'b0, bp, bq);
        wait_ticks(4);
        q1.push_back('{1'b0, 16'h00F0});
        send(1, 8'hF0, 1'b1, bp, bq);
        check("ferr_recover_data", {8'h00, d1}, 16'h00F0);
        wait_ticks(4);

        pat = 8'h7E;
        set_lane(1, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            set_lane(1, pat[i]);
            wait_ticks(16);
        end
        set_lane(1, pat[4]);
        wait_ticks(8);
        check("rst_busy_before", 16'(b1), 16'h1);
        rst1_n = 1'b0;
        #1;
        check("rst_mid_data", {8'h00, d1}, 16'h0000);
        check("rst_mid_valid", 16'(v1), 16'h0);
        check("rst_mid_ferr", 16'(e1), 16'h0);
        check("rst_mid_busy", 16'(b1), 16'h0);
        set_lane(1, 1'b1);
        wait_ticks(2);
        rst1_n = 1'b1;
        wait_ticks(4);
        q1.push_back('{1'b0, 16'h0081});
        send(1, 8'h81, 1'b1, bp, bq);
        wait_ticks(4);
    endtask

    task automatic run_dut2();
        bit bp, bq;
        q2.push_back('{1'b0, 16'h3CA5});
        send(2, 8'hA5, 1'b1, bp, bq);
        send(2, 8'h3C, 1'b1, bp, bq);
        wait_ticks(4);
        q2.push_back('{1'b1, 16'h3CA5});
        send(2, 8'h11, 1'b1, bp, bq);
        send(2, 8'h44, 1'b0, bp, bq);
        wait_ticks(4);
        q2.push_back('{1'b0, 16'h3322});
        send(2, 8'h22, 1'b1, bp, bq);
        send(2, 8'h33, 1'b1, bp, bq);
        wait_ticks(4);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_d1", {8'h00, d1}, 16'h0000);
        check("reset_v1", 16'(v1), 16'h0);
        check("reset_e1", 16'(e1), 16'h0);
        check("reset_b1", 16'(b1), 16'h0);
        check("reset_d2", d2, 16'h0000);
        check("reset_v2", 16'(v2), 16'h0);
        check("reset_e2", 16'(e2), 16'h0);
        check("reset_b2", 16'(b2), 16'h0);
        rst1_n = 1'b1;
        rst2_n = 1'b1;
        wait_ticks(4);
        fork
            run_dut1();
            run_dut2();
        join
        wait_ticks(4);
        check("dut1_pending_events", 16'(q1.size()), 16'h0);
        check("dut2_pending_events", 16'(q2.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/uart_rx_nbytes.md
Name: uart_rx_nbytes

Overview:
- RS-232 UART receive unit: 8N1 frames, LSB first, idle-high line.
- Oversamples the serial input with a single-cycle tick, validates the start bit at mid-bit, samples data and stop bits at bit centres.
- Assembles Nbytes consecutive bytes into one parallel word and flags completion with a one-cycle pulse.
- Sits between the board RX pin and downstream logic (FIFO / command decoder); the receive counterpart of the team's N-byte TX unit.

Parameters:
- Nbytes, 1, number of bytes (frames) assembled per output word.
- OVERSAMPLE, 16, rx_en ticks per bit period; even, >= 8.

Ports:
- clk  input  1  on-board 100 MHz system clock
- rst_n  input  1  asynchronous, active-low reset
- rx_en  input  1  single-clock pulse at OVERSAMPLE x baud rate
- rx_lane  input  1  asynchronous serial input stream
- rx_data  output  Nbytes*8  received word; byte k (k-th frame received, k=0 first) at rx_data[8k+7:8k]
- rx_valid  output  1  one-clock pulse: rx_data updated with a complete word
- rx_frame_err  output  1  one-clock pulse: stop bit sampled 0
- rx_busy  output  1  high while the FSM is not IDLE

Behaviour:
- Reset (async, rst_n=0): rx_data=0, rx_valid=0, rx_frame_err=0, rx_busy=0, FSM=IDLE, tick/bit/byte counters=0, synchronizer flops=1.
- rx_lane passes through a 2-FF synchronizer (reset to 1); all sampling uses the synchronized value. All state advances only on cycles with rx_en=1, except the output pulses.
- Tick counter: width clog2(OVERSAMPLE); cleared on every state transition.
- IDLE: on rx_en with line=0 -> START, tick=0.
- START: on rx_en tick++. When tick reaches OVERSAMPLE/2-1, sample: 1 -> IDLE (glitch rejected, nothing reported); 0 -> DATA, bit=0. Sampling point is now bit centre.
- DATA: on rx_en, when tick reaches OVERSAMPLE-1, sample line into shift register (LSB first: first sample -> bit 0), bit++. After the 8th sample -> STOP.
- STOP: when tick reaches OVERSAMPLE-1, sample:
  - 1: store byte in slot byte_idx. If byte_idx=Nbytes-1: load full word into rx_data, pulse rx_valid next cycle, byte_idx=0; else byte_idx++. -> IDLE, mid-stop-bit, so back-to-back frames are caught.
  - 0: pulse rx_frame_err, discard partial word, byte_idx=0, rx_data unchanged -> BREAK.
- BREAK: wait for rx_en with line=1 -> IDLE. No false start while the line is held low.
- rx_valid and rx_frame_err are registered: high exactly one clk cycle, the cycle after the rx_en that sampled the stop bit. They are never high together.
- rx_data holds its value until the next complete word; partially assembled bytes are never visible.
- rx_en=0: FSM and counters freeze. Line changes between ticks are ignored.
- Reset asserted mid-frame: immediate return to reset state; the partial word is lost.
- Latency: last stop-bit centre sample to rx_valid = 1 clk.

Test Plan:
- Common setup: clk 100 MHz, rx_en every 54 clk, bit period 16 ticks.
- Nbytes=1; drive frame 0x55 -> one rx_valid pulse; rx_data=8'h55; rx_frame_err never high; rx_busy falls at mid-stop-bit.
- Nbytes=2; frames 0xA5 then 0x3C back-to-back, no idle gap -> single rx_valid after second stop bit; rx_data=16'h3CA5; no pulse after the first byte.
- Glitch: rx_lane low for 3 rx_en ticks, then high -> no rx_valid, no rx_frame_err; rx_busy high then back to 0 within 8 ticks; a following frame 0x00 is received correctly.
- Framing error: frame 0x0F with stop bit 0, line held low 20 ticks, then high -> one rx_frame_err pulse, rx_data unchanged. Next valid frame 0xF0 -> rx_data=8'hF0, rx_valid pulse.
- Nbytes=2; first byte 0x11 valid, second byte has a bad stop bit; then frames 0x22, 0x33 -> rx_frame_err once; rx_valid once with rx_data=16'h3322 (0x11 discarded).
- Reset: assert rst_n=0 during data bit 4 of 0x7E -> all outputs 0 immediately. Release, send 0x81 -> rx_data=8'h81, one rx_valid pulse.
